// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: column strobes out, row senses in, decoded key events out.
// Latency: n/a (wiring only).
// Backpressure: none; key_valid is a fire-and-forget pulse with no ready.
//
// Signals:
//   col       - column drive, active-low, one bit low at a time (scanner -> keypad)
//   row       - row sense, active-low with pull-ups, asynchronous (keypad -> scanner)
//   key       - code of the last accepted key, row*4 + col
//   key_valid - one-cycle pulse when key updates
//   key_down  - level, high while any debounced key is held
interface keypad_scanner_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key;
    logic       key_valid;
    logic       key_down;

    // master: the scanner. slave: the keypad / board side.
    modport master (output col, key, key_valid, key_down, input row);
    modport slave  (input col, key, key_valid, key_down, output row);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with a row synchroniser, full-scan debounce and press events.
// Latency: a press is accepted after DEBOUNCE_SCANS identical full scans; key_valid follows one cycle later.
// Backpressure: none; the scan never stalls, and key_valid is a single-cycle pulse.
//
// Ports:
//   clk - system clock
//   rst - asynchronous active-high reset
//   kp  - keypad_scanner_if.master (col/row/key/key_valid/key_down)
module keypad_scanner #(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter int          DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);
    localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    logic [3:0]    row_meta_q, row_sync_q;
    logic [15:0]   div_q, div_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [15:0]   snap_q, snap_d;        // scan being assembled, bit r*4+c = row r, col c pressed
    logic [15:0]   last_q, last_d;        // previous full scan
    logic [15:0]   stable_q, stable_d;    // debounced key state
    logic [CW-1:0] cnt_q, cnt_d;          // consecutive identical full scans, saturating
    logic          upd_q, upd_d;          // stable changed on the previous cycle
    logic          was_idle_q, was_idle_d;// stable was all-released just before that change
    logic [3:0]    key_q, key_d;
    logic          key_valid_q, key_valid_d;
    logic          key_down_q, key_down_d;

    logic          wrap;
    logic          stable_onehot;
    logic [3:0]    stable_idx;

    assign wrap = (div_q == SCAN_DIV - 16'd1);

    // Exactly one key held: non-zero with only a single bit set.
    assign stable_onehot = (stable_q != 16'd0) && ((stable_q & (stable_q - 16'd1)) == 16'd0);

    always_comb begin
        stable_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (stable_q[i]) stable_idx = 4'(i);
        end
    end

    always_comb begin
        div_d       = wrap ? 16'd0 : div_q + 16'd1;
        col_idx_d   = wrap ? col_idx_q + 2'd1 : col_idx_q;
        snap_d      = snap_q;
        last_d      = last_q;
        stable_d    = stable_q;
        cnt_d       = cnt_q;
        upd_d       = 1'b0;
        was_idle_d  = was_idle_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_down_d  = (stable_q != 16'd0);

        // Last cycle of the column slot: rows have had SCAN_DIV-1 cycles to settle.
        if (wrap) begin
            for (int r = 0; r < 4; r++) begin
                snap_d[r*4 + int'(col_idx_q)] = ~row_sync_q[r];
            end
            // Column 3 completes the scan; snap_d now holds the full snapshot.
            if (col_idx_q == 2'd3) begin
                if (snap_d == last_q) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                end else begin
                    cnt_d = CW'(1);
                end
                last_d = snap_d;
                if (cnt_d == CNT_MAX && snap_d != stable_q) begin
                    stable_d   = snap_d;
                    upd_d      = 1'b1;
                    was_idle_d = (stable_q == 16'd0);
                end
            end
        end

        // Only a single key appearing out of the all-released state counts as a new press.
        if (upd_q && was_idle_q && stable_onehot) begin
            key_d       = stable_idx;
            key_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_q       <= 16'd0;
            col_idx_q   <= 2'd0;
            snap_q      <= 16'd0;
            last_q      <= 16'd0;
            stable_q    <= 16'd0;
            cnt_q       <= '0;
            upd_q       <= 1'b0;
            was_idle_q  <= 1'b0;
            key_q       <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            row_meta_q  <= kp.row;
            row_sync_q  <= row_meta_q;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            snap_q      <= snap_d;
            last_q      <= last_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            upd_q       <= upd_d;
            was_idle_q  <= was_idle_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign kp.col       = ~(4'b0001 << col_idx_q);
    assign kp.key       = key_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;
endmodule
